// File: rtl/pll_lock_ctrl_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the FSM state encoding, the count saturation limit and the counter sizing rule.
package pll_lock_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    FILTER,
    HOLD,
    RUN
  } state_t;

  localparam logic [7:0] COUNT_MAX = 8'd255;

  // Width that holds the largest count parameter, plus one spare bit.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous reset to 0.
// Used for PLL LOCK and other asynchronous status inputs.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_chain <= '0;
    else       r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock supervisor: pulses PLL reset, filters LOCK, and sequences the
// downstream system reset with timeout-driven retries.
module pll_lock_ctrl
  import pll_lock_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 256,
  parameter int RELEASE_DELAY  = 1024,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int PLL_RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked_async,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int CW = cnt_width(LOCK_FILTER, RELEASE_DELAY, LOCK_TIMEOUT, PLL_RST_CYCLES);
  localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LF_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RELEASE_DELAY - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == COUNT_MAX) ? v : v + 8'd1;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_tcnt, w_tcnt_nxt;
  logic [7:0]    r_retry_count, r_loss_count;
  logic          w_locked_s, w_lock_lost, w_timeout, w_retry_inc, w_loss_inc;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (locked_async),
    .o_q   (w_locked_s)
  );

  assign w_lock_lost = ((r_state == HOLD) || (r_state == RUN)) && !w_locked_s;
  assign w_timeout   = ((r_state == WAIT_LOCK) || (r_state == FILTER)) && (r_tcnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tcnt_nxt  = r_tcnt;
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    if (force_relock) begin
      w_state_nxt = PLL_RESET;
      w_cnt_nxt   = '0;
      w_loss_inc  = w_lock_lost;
    end else begin
      case (r_state)
        PLL_RESET: begin
          if (r_cnt == PR_LAST) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
            w_tcnt_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          w_tcnt_nxt = r_tcnt + CW'(1);
          if (w_timeout) begin
            w_state_nxt = PLL_RESET;
            w_cnt_nxt   = '0;
            w_retry_inc = 1'b1;
          end else if (w_locked_s) begin
            w_state_nxt = FILTER;
            w_cnt_nxt   = '0;
          end
        end
        FILTER: begin
          w_tcnt_nxt = r_tcnt + CW'(1);
          if (w_locked_s && (r_cnt == LF_LAST)) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = '0;
          end else if (w_timeout) begin
            w_state_nxt = PLL_RESET;
            w_cnt_nxt   = '0;
            w_retry_inc = 1'b1;
          end else if (!w_locked_s) begin
            w_state_nxt = WAIT_LOCK;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        // A drop on the final HOLD cycle still aborts, so release is never early.
        HOLD: begin
          if (w_lock_lost) begin
            w_state_nxt = WAIT_LOCK;
            w_tcnt_nxt  = '0;
            w_loss_inc  = 1'b1;
          end else if (r_cnt == RD_LAST) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        RUN: begin
          if (w_lock_lost) begin
            w_state_nxt = WAIT_LOCK;
            w_tcnt_nxt  = '0;
            w_loss_inc  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = PLL_RESET;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= PLL_RESET;
      r_cnt         <= '0;
      r_tcnt        <= '0;
      r_retry_count <= '0;
      r_loss_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      if (w_retry_inc) r_retry_count <= sat_inc(r_retry_count);
      if (w_loss_inc)  r_loss_count  <= sat_inc(r_loss_count);
    end
  end

  assign pll_rst         = (r_state == PLL_RESET);
  assign sys_rst         = (r_state != RUN);
  assign ready           = (r_state == RUN);
  assign retry_count     = r_retry_count;
  assign lock_loss_count = r_loss_count;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small parameters; edge counts are
// worked out by hand from the sync/filter/hold/timeout lengths.
module tb_pll_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_async = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [7:0] retry_count, lock_loss_count;

  int n_cmp = 0;
  int n_mis = 0;

  pll_lock_ctrl #(
    .SYNC_STAGES    (2),
    .LOCK_FILTER    (4),
    .RELEASE_DELAY  (8),
    .LOCK_TIMEOUT   (64),
    .PLL_RST_CYCLES (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .locked_async    (locked_async),
    .force_relock    (force_relock),
    .pll_rst         (pll_rst),
    .sys_rst         (sys_rst),
    .ready           (ready),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic p, input logic s, input logic r,
                            input logic [7:0] rc, input logic [7:0] lc);
    check_val({tag, ".pll_rst"}, 32'(pll_rst), 32'(p));
    check_val({tag, ".sys_rst"}, 32'(sys_rst), 32'(s));
    check_val({tag, ".ready"}, 32'(ready), 32'(r));
    check_val({tag, ".retry"}, 32'(retry_count), 32'(rc));
    check_val({tag, ".loss"}, 32'(lock_loss_count), 32'(lc));
  endtask

  initial begin
    // Reset state
    edges(3);
    check_outs("reset", 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);

    // Lock after reset: PLL reset pulse of 3 cycles, then release 15 edges after first sample
    rst = 1'b0;
    edges(2);
    check_val("s1.pll_rst_hi", 32'(pll_rst), 32'd1);
    edges(1);
    check_val("s1.pll_rst_lo", 32'(pll_rst), 32'd0);
    edges(2);
    locked_async = 1'b1;
    edges(14);
    check_outs("s1.pre_release", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    edges(1);
    check_outs("s1.release", 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    edges(5);
    check_val("s1.run_stable", 32'(ready), 32'd1);

    // Lock loss in RUN: one-cycle drop, sys_rst at edge 3, re-release at edge 16
    locked_async = 1'b0;
    edges(1);
    locked_async = 1'b1;
    edges(1);
    check_outs("s3.edge2", 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    edges(1);
    check_outs("s3.edge3", 1'b0, 1'b1, 1'b0, 8'd0, 8'd1);
    edges(12);
    check_val("s3.edge15_ready", 32'(ready), 32'd0);
    edges(1);
    check_val("s3.edge16_ready", 32'(ready), 32'd1);
    check_val("s3.edge16_sys_rst", 32'(sys_rst), 32'd0);

    // force_relock coincident with lock loss seen in RUN (loss count goes 1 -> 2)
    locked_async = 1'b0;
    edges(2);
    force_relock = 1'b1;
    edges(1);
    force_relock = 1'b0;
    check_outs("s4.relock", 1'b1, 1'b1, 1'b0, 8'd0, 8'd2);
    edges(2);
    check_val("s4.pll_rst_hi", 32'(pll_rst), 32'd1);
    edges(1);
    check_val("s4.pll_rst_lo", 32'(pll_rst), 32'd0);

    // Glitchy lock 1,1,1,0: filter never completes, timeout on 64th WAIT/FILTER edge
    for (int i = 0; i < 63; i++) begin
      locked_async = (i % 4) != 3;
      edges(1);
    end
    check_outs("s2.pre_timeout", 1'b0, 1'b1, 1'b0, 8'd0, 8'd2);
    locked_async = 1'b1;
    edges(1);
    check_outs("s2.timeout", 1'b1, 1'b1, 1'b0, 8'd1, 8'd2);
    locked_async = 1'b0;
    edges(2);
    check_val("s2.pll_rst_hi", 32'(pll_rst), 32'd1);
    edges(1);
    check_val("s2.pll_rst_lo", 32'(pll_rst), 32'd0);

    // Saturation: each retry period is 64 + 3 = 67 edges with lock never asserted
    edges(64 + 253 * 67 - 1);
    check_val("sat.retry_254", 32'(retry_count), 32'd254);
    edges(1);
    check_val("sat.retry_255", 32'(retry_count), 32'd255);
    check_val("sat.pll_rst", 32'(pll_rst), 32'd1);
    edges(67 * 50);
    check_val("sat.retry_hold", 32'(retry_count), 32'd255);
    check_val("sat.loss", 32'(lock_loss_count), 32'd2);

    // rst during HOLD: now in PLL_RESET with cnt 0; lock up and reach HOLD
    locked_async = 1'b1;
    edges(10);
    check_outs("s6.in_hold", 1'b0, 1'b1, 1'b0, 8'd255, 8'd2);
    rst = 1'b1;
    edges(1);
    check_outs("s6.reset", 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    rst = 1'b0;
    edges(2);
    check_val("s6.pll_rst_hi", 32'(pll_rst), 32'd1);
    edges(1);
    check_val("s6.pll_rst_lo", 32'(pll_rst), 32'd0);
    edges(12);
    check_val("s6.pre_release", 32'(ready), 32'd0);
    edges(1);
    check_outs("s6.release", 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Lock supervisor and reset sequencer for the ECP5 EHXPLLL in the APSK demo. It runs on the 25 MHz board clock, which is the PLL reference, and drives the PLL `RST` pin; the PLL must be instantiated with `PLLRST_ENA("ENABLED")`. It consumes the asynchronous `LOCK` output, filters it, and releases a system reset to the 30.7143 MHz datapath only after lock has been stable. If lock is not achieved within a timeout, it re-pulses PLL reset and retries.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `locked_async` synchronizer (≥2).
- `LOCK_FILTER`, 256: consecutive synchronized-lock cycles required before HOLD (≥1).
- `RELEASE_DELAY`, 1024: cycles `sys_rst` stays high in HOLD (≥1).
- `LOCK_TIMEOUT`, 1048576: cycles allowed in WAIT_LOCK+FILTER before a retry (greater than `LOCK_FILTER`).
- `PLL_RST_CYCLES`, 16: width of the `pll_rst` pulse (≥1).

Ports:
- `clk` in 1: 25 MHz reference clock.
- `rst` in 1: synchronous, active-high reset.
- `locked_async` in 1: PLL `LOCK`, asynchronous to `clk`.
- `force_relock` in 1: single-cycle request to restart the PLL.
- `pll_rst` out 1: drives the PLL `RST` pin.
- `sys_rst` out 1: active-high reset for the downstream domain (level). The consumer resynchronizes it.
- `ready` out 1: high only in RUN.
- `retry_count` out 8: number of timeouts, saturating.
- `lock_loss_count` out 8: number of lock drops while in HOLD or RUN, saturating.

## Operation
- `locked_s` is the output of a `SYNC_STAGES` flop chain on `locked_async`. The chain resets to 0.
- All outputs are Moore-decoded from the state register. There is one shared counter `cnt` plus a timeout counter `tcnt`.
- States:
  - PLL_RESET: `pll_rst=1`, `sys_rst=1`. Lasts `PLL_RST_CYCLES` cycles, then goes to WAIT_LOCK. On exit, `tcnt` is cleared.
  - WAIT_LOCK: `pll_rst=0`, `sys_rst=1`, `tcnt` increments. If `locked_s=1`, go to FILTER with `cnt=0`.
  - FILTER: `sys_rst=1`, `tcnt` increments.
    - If `locked_s=0`, go back to WAIT_LOCK; `tcnt` is not cleared.
    - After `LOCK_FILTER` consecutive cycles with `locked_s=1`, go to HOLD.
  - HOLD: `sys_rst=1`.
    - After `RELEASE_DELAY` cycles, go to RUN.
    - If `locked_s=0`, go to WAIT_LOCK, clear `tcnt`, and increment `lock_loss_count`.
  - RUN: `sys_rst=0`, `ready=1`. If `locked_s=0`, go to WAIT_LOCK, clear `tcnt`, and increment `lock_loss_count`.
- Timeout: in WAIT_LOCK or FILTER, when `tcnt` reaches `LOCK_TIMEOUT-1`, go to PLL_RESET and increment `retry_count`.
- Priority within one cycle, highest first:
  - `rst`.
  - `force_relock`: go to PLL_RESET from any state. A lock loss detected in the same cycle still increments `lock_loss_count`.
  - Completion of FILTER, which wins over timeout in the same cycle.
  - Timeout.
  - Lock loss.
- Both count outputs saturate at 255 and clear only on `rst`.
- Counter width is `$clog2` of the largest count parameter plus 1. There are no wrap-around paths.

## Timing
- Reset values while `rst` is high and on the cycle after it:
  - state is PLL_RESET;
  - `pll_rst=1`, `sys_rst=1`, `ready=0`;
  - `retry_count=0`, `lock_loss_count=0`;
  - the sync chain is 0.
- `pll_rst` is high for exactly `PLL_RST_CYCLES` cycles after `rst` falls, and for the same width after a timeout or `force_relock`.
- Number the first rising edge that samples `locked_async=1` in WAIT_LOCK as edge 1:
  - FILTER is entered at edge `SYNC_STAGES+1`;
  - HOLD is entered at edge `SYNC_STAGES+1+LOCK_FILTER`;
  - `sys_rst` falls and `ready` rises at edge `SYNC_STAGES+1+LOCK_FILTER+RELEASE_DELAY`.
- Lock loss in RUN: `sys_rst` rises at edge `SYNC_STAGES+1` after `locked_async` falls. The FSM must never release `sys_rst` faster than this.
- A `rst` assertion mid-sequence takes effect at the next edge and restarts from PLL_RESET.

## Structure
- Package `pll_lock_ctrl_pkg`:
  - state enum (PLL_RESET, WAIT_LOCK, FILTER, HOLD, RUN);
  - `COUNT_MAX=255` saturation constant;
  - counter-width helper function.
- Sub-module `sync_bit`: parameterized `SYNC_STAGES` flop chain with synchronous reset to 0, reused for other async status inputs.

## Test plan
All scenarios use `SYNC_STAGES=2`, `LOCK_FILTER=4`, `RELEASE_DELAY=8`, `LOCK_TIMEOUT=64`, `PLL_RST_CYCLES=3`.
- Lock after reset: release `rst`, raise `locked_async` at cycle 10 -> `pll_rst` high cycles 0–2, `sys_rst` falls and `ready` rises exactly 15 edges after the first sampling edge, counts stay 0.
- Glitchy lock: `locked_async` pattern 1,1,1,0 repeated -> FILTER never completes, timeout after 64 cycles, `pll_rst` pulses 3 cycles, `retry_count=1`.
- Lock loss in RUN: drop `locked_async` for 1 cycle -> `sys_rst` high 3 edges later, `ready=0`, `lock_loss_count=1`, full 15-edge re-release once lock returns.
- `force_relock` in RUN coincident with lock drop -> PLL_RESET next cycle, `pll_rst` 3 cycles, `lock_loss_count=1`.
- Saturation: 300 forced timeouts with lock never asserted -> `retry_count=255`.
- `rst` asserted during HOLD -> all outputs at reset values next cycle, counts 0, sequence restarts.
